// File: rtl/debug_dump_sequencer_if.sv
// Bundle of the UART command/response link and the datapath run-control
// signals seen by the debug dump sequencer.
//   master : the sequencer side (drives tx and datapath control)
//   slave  : the environment side (UART core and MIPS datapath)
interface debug_dump_sequencer_if #(
   parameter int DUMP_BYTES = 172
);
   logic                    rx_done_tick;
   logic [7:0]              rx_bus;
   logic                    tx_done_tick;
   logic                    tx_write;
   logic [7:0]              tx_bus;
   logic [DUMP_BYTES*8-1:0] dp_bus;
   logic                    dp_halt;
   logic                    dp_clk_en;
   logic                    dp_reset;

   modport master (
      input  rx_done_tick, rx_bus, tx_done_tick, dp_bus, dp_halt,
      output tx_write, tx_bus, dp_clk_en, dp_reset
   );

   modport slave (
      output rx_done_tick, rx_bus, tx_done_tick, dp_bus, dp_halt,
      input  tx_write, tx_bus, dp_clk_en, dp_reset
   );
endinterface

// File: rtl/debug_dump_sequencer.sv
// Run-control sequencer between the UART command link and the MIPS datapath.
// Decodes single-byte host commands, runs the datapath for one cycle (step)
// or until HALT (continuous), then streams the 32-bit cycle count followed
// by the full datapath snapshot back over UART tx, one byte per handshake.
module debug_dump_sequencer #(
   parameter int         DUMP_BYTES = 172,
   parameter logic [7:0] CMD_STEP   = 8'h73,
   parameter logic [7:0] CMD_CONT   = 8'h63,
   parameter logic [7:0] CMD_RST    = 8'h72
) (
   input logic                     clk,
   input logic                     reset,
   debug_dump_sequencer_if.master  bus
);

   localparam int FRAME_BYTES = 4 + DUMP_BYTES;
   localparam int IDX_W       = $clog2(FRAME_BYTES);
   localparam int SNAP_W      = $clog2(DUMP_BYTES);

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_BYTES - 1);
   localparam logic [IDX_W-1:0] CNT_BYTES = IDX_W'(4);

   typedef enum logic [7:0] {
      IDLE      = 8'b0000_0001,
      STEP_WAIT = 8'b0000_0010,
      STEP      = 8'b0000_0100,
      CONT      = 8'b0000_1000,
      SNAP      = 8'b0001_0000,
      SEND      = 8'b0010_0000,
      WAIT_TX   = 8'b0100_0000,
      FIN       = 8'b1000_0000
   } state_t;

   state_t           state, state_nxt;
   logic [31:0]      cycle_cnt;
   logic [IDX_W-1:0] byte_idx;
   logic             halted;
   logic [7:0]       tx_bus_q;
   logic [7:0]       snap_mem [DUMP_BYTES];

   logic             cmd_step, cmd_cont, cmd_rst;
   logic             last_byte;
   logic [IDX_W-1:0] snap_idx;
   logic [7:0]       frame_byte;

   assign cmd_step  = bus.rx_done_tick && (bus.rx_bus == CMD_STEP);
   assign cmd_cont  = bus.rx_done_tick && (bus.rx_bus == CMD_CONT);
   assign cmd_rst   = bus.rx_done_tick && (bus.rx_bus == CMD_RST);
   assign last_byte = (byte_idx == LAST_IDX);
   assign snap_idx  = byte_idx - CNT_BYTES;

   // Datapath control and tx strobe decoded straight from the registered state.
   assign bus.dp_clk_en = (state == STEP) || ((state == CONT) && !bus.dp_halt);
   assign bus.dp_reset  = (state == IDLE);
   assign bus.tx_write  = (state == SEND);
   assign bus.tx_bus    = (state == SEND) ? frame_byte : tx_bus_q;

   // Select frame byte: cycle count LSB first, then snapshot bytes in order.
   always_comb begin
      // NOTE: assigning a default before any branch keeps always_comb free of inferred latches.
      frame_byte = 8'h00;
      if (byte_idx < CNT_BYTES)
         frame_byte = cycle_cnt[{byte_idx[1:0], 3'b000} +: 8];
      else
         frame_byte = snap_mem[snap_idx[SNAP_W-1:0]];
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state decode; commands outside the waiting states are dropped.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (cmd_step)      state_nxt = STEP;
            else if (cmd_cont) state_nxt = CONT;
         end
         STEP_WAIT: begin
            if (cmd_step)      state_nxt = STEP;
            else if (cmd_cont) state_nxt = CONT;
            else if (cmd_rst)  state_nxt = IDLE;
         end
         STEP:    state_nxt = SNAP;
         CONT:    if (bus.dp_halt) state_nxt = SNAP;
         SNAP:    state_nxt = SEND;
         SEND:    state_nxt = WAIT_TX;
         WAIT_TX: begin
            if (bus.tx_done_tick) begin
               if (!last_byte)  state_nxt = SEND;
               else if (halted) state_nxt = FIN;
               else             state_nxt = STEP_WAIT;
            end
         end
         FIN:     if (cmd_rst) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Cycle counter: cleared while idle, counts every enabled datapath edge.
   always_ff @(posedge clk) begin
      if (reset || (state == IDLE))
         cycle_cnt <= 32'd0;
      else if (bus.dp_clk_en)
         cycle_cnt <= cycle_cnt + 32'd1;
   end

   // Frame byte pointer, halt flag capture and held tx byte.
   always_ff @(posedge clk) begin
      if (reset) begin
         byte_idx <= '0;
         halted   <= 1'b0;
         tx_bus_q <= 8'h00;
      end else begin
         if (state == SNAP) begin
            byte_idx <= '0;
            halted   <= bus.dp_halt;
         end else if ((state == WAIT_TX) && bus.tx_done_tick && !last_byte) begin
            byte_idx <= byte_idx + IDX_W'(1);
         end
         if (state == SEND)
            tx_bus_q <= frame_byte;
      end
   end

   // Snapshot capture; contents are only read after SNAP has written them.
   always_ff @(posedge clk) begin
      // NOTE: the snapshot array has no reset; every entry is written in SNAP before any read.
      if (state == SNAP) begin
         for (int k = 0; k < DUMP_BYTES; k++)
            snap_mem[k] <= bus.dp_bus[8*k +: 8];
      end
   end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Directed bench for debug_dump_sequencer: reset, step dump, continuous run
// to halt, tx back-pressure, reset mid-dump and ignored commands.
module tb_debug_dump_sequencer;

   localparam int         DUMP_BYTES = 172;
   localparam int         N          = DUMP_BYTES + 4;
   localparam logic [7:0] CMD_STEP   = 8'h73;
   localparam logic [7:0] CMD_CONT   = 8'h63;
   localparam logic [7:0] CMD_RST    = 8'h72;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   debug_dump_sequencer_if #(.DUMP_BYTES(DUMP_BYTES)) ifc ();

   debug_dump_sequencer #(
      .DUMP_BYTES (DUMP_BYTES),
      .CMD_STEP   (CMD_STEP),
      .CMD_CONT   (CMD_CONT),
      .CMD_RST    (CMD_RST)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.master)
   );

   int   checks    = 0;
   int   failures  = 0;
   int   en_edges  = 0;
   int   wr_edges  = 0;
   int   consec_wr = 0;
   logic prev_wr   = 1'b0;
   int   e0, w0;

   // Edge monitors: enabled datapath edges, tx strobes, back-to-back strobes.
   always @(posedge clk) begin
      if (ifc.dp_clk_en === 1'b1) en_edges <= en_edges + 1;
      if (ifc.tx_write === 1'b1)  wr_edges <= wr_edges + 1;
      if ((ifc.tx_write === 1'b1) && prev_wr) consec_wr <= consec_wr + 1;
      prev_wr <= (ifc.tx_write === 1'b1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] pat(input int k);
      return 8'((k * 7 + 3) & 255);
   endfunction

   function automatic logic [7:0] exp_byte(input int idx, input logic [31:0] cnt);
      if (idx < 4) return cnt[8*idx +: 8];
      return pat(idx - 4);
   endfunction

   task automatic set_pattern(input bit alt);
      for (int k = 0; k < DUMP_BYTES; k++)
         ifc.dp_bus[8*k +: 8] = alt ? ~pat(k) : pat(k);
   endtask

   // Called at a negedge; the command is sampled by the following posedge.
   task automatic send_cmd(input logic [7:0] b);
      ifc.rx_bus       = b;
      ifc.rx_done_tick = 1'b1;
      @(negedge clk);
      ifc.rx_done_tick = 1'b0;
   endtask

   // Receive one dump frame, acknowledging each byte after a gap.
   task automatic run_dump(input logic [31:0] cnt, input int stall_idx,
                           input int abort_idx, input int cmd_idx);
      int   t;
      int   bad;
      int   bad_all;
      int   gap;
      logic [7:0] held;
      bad_all = 0;
      for (int i = 0; i < N; i++) begin
         t = 0;
         while ((ifc.tx_write !== 1'b1) && (t < 2000)) begin
            @(negedge clk);
            t++;
         end
         if (ifc.tx_write !== 1'b1) begin
            check($sformatf("tx_write_timeout_byte%0d", i), 32'd0, 32'd1);
            set_pattern(0);
            return;
         end
         check($sformatf("byte%0d", i), 32'(ifc.tx_bus), 32'(exp_byte(i, cnt)));
         if (i == 0) set_pattern(1);
         if (i == abort_idx) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check("abort_tx_write", 32'(ifc.tx_write), 32'd0);
            check("abort_dp_reset", 32'(ifc.dp_reset), 32'd1);
            check("abort_dp_clk_en", 32'(ifc.dp_clk_en), 32'd0);
            set_pattern(0);
            return;
         end
         held = ifc.tx_bus;
         bad  = 0;
         gap  = (i == stall_idx) ? 1000 : 10;
         for (int j = 0; j < gap; j++) begin
            @(negedge clk);
            if ((ifc.tx_write !== 1'b0) || (ifc.tx_bus !== held)) bad++;
            if ((i == cmd_idx) && (j == 2)) begin
               ifc.rx_bus       = CMD_CONT;
               ifc.rx_done_tick = 1'b1;
            end else begin
               ifc.rx_done_tick = 1'b0;
            end
         end
         if (i == stall_idx) check("stall_quiet", bad, 0);
         else bad_all += bad;
         ifc.tx_done_tick = 1'b1;
         @(negedge clk);
         ifc.tx_done_tick = 1'b0;
      end
      check("gap_quiet", bad_all, 0);
      set_pattern(0);
   endtask

   initial begin
      int k;
      ifc.rx_done_tick = 1'b0;
      ifc.rx_bus       = 8'h00;
      ifc.tx_done_tick = 1'b0;
      ifc.dp_halt      = 1'b0;
      set_pattern(0);

      // Reset state and quiet idle.
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_dp_reset", 32'(ifc.dp_reset), 32'd1);
      check("rst_dp_clk_en", 32'(ifc.dp_clk_en), 32'd0);
      check("rst_tx_write", 32'(ifc.tx_write), 32'd0);
      check("rst_tx_bus", 32'(ifc.tx_bus), 32'd0);
      reset = 1'b0;
      e0 = en_edges; w0 = wr_edges;
      repeat (10) @(negedge clk);
      check("idle_no_en", en_edges - e0, 0);
      check("idle_no_wr", wr_edges - w0, 0);
      check("idle_dp_reset", 32'(ifc.dp_reset), 32'd1);

      // Unknown command in IDLE is ignored.
      e0 = en_edges;
      send_cmd(8'h78);
      repeat (5) @(negedge clk);
      check("x_no_en", en_edges - e0, 0);
      check("x_dp_reset", 32'(ifc.dp_reset), 32'd1);

      // Single step and full dump.
      e0 = en_edges; w0 = wr_edges;
      send_cmd(CMD_STEP);
      check("step_latency", 32'(ifc.dp_clk_en), 32'd1);
      @(negedge clk);
      check("step_one_cycle", 32'(ifc.dp_clk_en), 32'd0);
      run_dump(32'd1, -1, -1, -1);
      check("step_en_edges", en_edges - e0, 1);
      check("step_wr_count", wr_edges - w0, N);
      check("step_wait_dp_reset", 32'(ifc.dp_reset), 32'd0);

      // Continuous run until halt after 20 enabled cycles.
      e0 = en_edges;
      send_cmd(CMD_CONT);
      k = 0;
      for (int t = 0; t < 200; t++) begin
         if (ifc.dp_clk_en === 1'b1) k++;
         if (k == 20) break;
         @(negedge clk);
      end
      check("cont_reached20", k, 20);
      @(posedge clk);
      #1 ifc.dp_halt = 1'b1;
      @(negedge clk);
      check("halt_stops_en", 32'(ifc.dp_clk_en), 32'd0);
      run_dump(32'd21, -1, -1, -1);
      check("cont_en_edges", en_edges - e0, 20);

      // FIN ignores step, leaves on 'r'.
      e0 = en_edges; w0 = wr_edges;
      send_cmd(CMD_STEP);
      repeat (5) @(negedge clk);
      check("fin_no_en", en_edges - e0, 0);
      check("fin_no_wr", wr_edges - w0, 0);
      check("fin_dp_reset", 32'(ifc.dp_reset), 32'd0);
      send_cmd(CMD_RST);
      check("rst_cmd_idle", 32'(ifc.dp_reset), 32'd1);
      ifc.dp_halt = 1'b0;

      // Back-pressure stall at byte 3, then reset at byte 50.
      e0 = en_edges;
      send_cmd(CMD_STEP);
      run_dump(32'd1, 3, 50, -1);
      check("abort_en_edges", en_edges - e0, 1);

      // Fresh dump after abort; 'c' during WAIT_TX is dropped.
      e0 = en_edges; w0 = wr_edges;
      send_cmd(CMD_STEP);
      run_dump(32'd1, -1, -1, 20);
      check("drop_cmd_en_edges", en_edges - e0, 1);
      check("redump_wr_count", wr_edges - w0, N);
      check("redump_dp_reset", 32'(ifc.dp_reset), 32'd0);
      check("no_consec_wr", consec_wr, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
